// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word read/write per request, inserts
// WAIT_CYCLES wait states, then returns a single-cycle ack with rdata/err.
module dmem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
   localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [3:0]    cnt;
   logic          lat_we;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;

   logic          accept;
   logic          enter_resp;
   logic          cur_we;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic          cur_bad;
   logic [IW-1:0] cur_idx;

   logic [31:0]   mem [DEPTH];

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_W);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   // With zero wait states the access completes on the accept edge itself,
   // so the RAM and rdata must see the live request instead of the latches.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      enter_resp = 1'b0;
      cur_we     = lat_we;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      case (state)
         IDLE: begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            if (req) begin
               accept = 1'b1;
               if (NO_WAIT) begin
                  next_state = RESP;
                  enter_resp = 1'b1;
               end else begin
                  next_state = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt == LAST_CNT) begin
               next_state = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      cur_bad = addr_bad(cur_addr);
      cur_idx = cur_addr[IW+1:2];
   end

   always_ff @(posedge clk) begin
      if (!rst && enter_resp && cur_we && !cur_bad) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (enter_resp) begin
         rdata <= (cur_we || cur_bad) ? 32'd0 : mem[cur_idx];
      end
   end

   // Reset gates the handshake outputs so a reset in RESP drops the ack.
   assign ready = (state == IDLE) && !rst;
   assign ack   = (state == RESP) && !rst;
   assign err   = ack && addr_bad(lat_addr);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a
// zero-wait instance share clock, reset and request payload.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        req0;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready, ack, err;
   logic [31:0] rdata;
   logic        ready0, ack0, err0;
   logic [31:0] rdata0;

   logic        sel;
   logic        s_ready, s_ack, s_err;
   logic [31:0] s_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .ack(ack), .rdata(rdata), .err(err)
   );

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
   );

   assign s_ready = sel ? ready0 : ready;
   assign s_ack   = sel ? ack0   : ack;
   assign s_err   = sel ? err0   : err;
   assign s_rdata = sel ? rdata0 : rdata;

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req   = r;
      we    = w;
      addr  = a;
      wdata = d;
   endtask

   // One complete access on the selected instance, checking every cycle
   // from accept through the return to idle.
   task automatic do_access(input string tag, input bit b, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rdata);
      int lat;
      lat = b ? 1 : 3;
      sel = b;
      #1;
      check_output({tag, ":ready_idle"}, 32'(s_ready), 32'd1);
      we    = w;
      addr  = a;
      wdata = d;
      if (b) req0 = 1'b1;
      else   req  = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         next_cycle();
         if (k == 1) begin
            req  = 1'b0;
            req0 = 1'b0;
         end
         #1;
         check_output({tag, ":ack"}, 32'(s_ack), 32'(k == lat));
         check_output({tag, ":ready_busy"}, 32'(s_ready), 32'd0);
         if (k == lat) begin
            check_output({tag, ":err"}, 32'(s_err), 32'(exp_err));
            check_output({tag, ":rdata"}, s_rdata, exp_rdata);
         end
      end
      next_cycle();
      #1;
      check_output({tag, ":ready_after"}, 32'(s_ready), 32'd1);
      check_output({tag, ":ack_after"}, 32'(s_ack), 32'd0);
      check_output({tag, ":err_after"}, 32'(s_err), 32'd0);
      check_output({tag, ":rdata_hold"}, s_rdata, exp_rdata);
      next_cycle();
      sel = 1'b0;
   endtask

   initial begin
      sel  = 1'b0;
      rst  = 1'b1;
      req0 = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
      next_cycle();
      next_cycle();
      #1;
      check_output("rst:ready", 32'(ready), 32'd0);
      check_output("rst:ack", 32'(ack), 32'd0);
      check_output("rst:err", 32'(err), 32'd0);
      check_output("rst:rdata", rdata, 32'd0);
      rst = 1'b0;
      #1;
      check_output("rst:ready_after", 32'(ready), 32'd1);
      check_output("rst:ready0_after", 32'(ready0), 32'd1);
      next_cycle();

      do_access("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      do_access("t1_rd", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      do_access("t2_rd_mis", 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
      do_access("t2_wr_mis", 1'b0, 1'b1, 32'h12, 32'h11111111, 1'b1, 32'h0);
      do_access("t2_rd_chk", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      do_access("t3_rd_oor", 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
      do_access("t3_wr_top", 1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
      do_access("t3_rd_top", 1'b0, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
      do_access("t3_wr_high", 1'b0, 1'b1, 32'h40000010, 32'h22222222, 1'b1, 32'h0);
      do_access("t3_rd_alias", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // req pulsed while BUSY carries a write that must be dropped
      apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0);
      next_cycle();
      apply_stimulus(1'b1, 1'b1, 32'h10, 32'h0);
      #1;
      check_output("t4_pulse:ready", 32'(ready), 32'd0);
      check_output("t4_pulse:ack1", 32'(ack), 32'd0);
      next_cycle();
      apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0);
      #1;
      check_output("t4_pulse:ack2", 32'(ack), 32'd0);
      next_cycle();
      #1;
      check_output("t4_pulse:ack3", 32'(ack), 32'd1);
      check_output("t4_pulse:rdata", rdata, 32'hDEADBEEF);
      for (int i = 4; i <= 6; i++) begin
         next_cycle();
         #1;
         check_output("t4_pulse:no_extra_ack", 32'(ack), 32'd0);
         check_output("t4_pulse:ready_idle", 32'(ready), 32'd1);
      end
      next_cycle();
      do_access("t4_rd_chk", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      apply_stimulus(1'b1, 1'b0, 32'hFFC, 32'h0);
      for (int i = 0; i <= 8; i++) begin
         if (i == 8) req = 1'b0;
         #1;
         check_output("t4_held:ack", 32'(ack), 32'((i == 3) || (i == 7)));
         check_output("t4_held:ready", 32'(ready), 32'((i == 0) || (i == 4) || (i == 8)));
         if ((i == 3) || (i == 7)) check_output("t4_held:rdata", rdata, 32'hCAFEF00D);
         next_cycle();
      end
      #1;
      check_output("t4_held:idle", 32'(ack), 32'd0);
      next_cycle();

      do_access("t5_wr", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0);
      do_access("t5_rd", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);
      do_access("t5_mis", 1'b1, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0);

      do_access("t6_prior", 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
      apply_stimulus(1'b1, 1'b1, 32'h20, 32'h12345678);
      next_cycle();
      req = 1'b0;
      rst = 1'b1;
      #1;
      check_output("t6_busy:ready", 32'(ready), 32'd0);
      check_output("t6_busy:ack", 32'(ack), 32'd0);
      next_cycle();
      rst = 1'b0;
      #1;
      check_output("t6_after:ready", 32'(ready), 32'd1);
      check_output("t6_after:ack", 32'(ack), 32'd0);
      check_output("t6_after:rdata", rdata, 32'd0);
      next_cycle();
      #1;
      check_output("t6_after:no_ack", 32'(ack), 32'd0);
      next_cycle();
      do_access("t6_rd", 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BADF00D);

      // reset landing in RESP drops the ack but the write already happened
      apply_stimulus(1'b1, 1'b1, 32'h24, 32'h00000077);
      next_cycle();
      req = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      #1;
      check_output("t6_resp:ack", 32'(ack), 32'd0);
      check_output("t6_resp:err", 32'(err), 32'd0);
      check_output("t6_resp:ready", 32'(ready), 32'd0);
      next_cycle();
      rst = 1'b0;
      #1;
      check_output("t6_resp:ready_after", 32'(ready), 32'd1);
      next_cycle();
      do_access("t6_rd_resp", 1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 32'h00000077);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
